// File: rtl/imem_responder.sv
// Byte-organised instruction memory answering 32-bit little-endian fetches
// over a valid/ready response channel, with fault and HALT detection.
module imem_responder #(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic              rsp_fault,
  output logic              halt_seen,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data
);

  // state  | meaning
  // IDLE   | ready for a fetch request
  // READ   | assembling the word one byte per cycle
  // RESP   | response held until the fetch stage takes it
  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic              fault_q, fault_d;
  logic              halt_q, halt_d;

  logic [7:0]        mem_q [MEM_BYTES];
  logic [ADDR_W-1:0] rd_idx;
  logic [7:0]        rd_byte;
  logic              bad_addr;

  // Aligned, in-range addresses never carry out of the ADDR_W-bit sum.
  assign rd_idx   = addr_q + ADDR_W'(cnt_q);
  assign rd_byte  = mem_q[rd_idx];
  assign bad_addr = (req_addr[63:ADDR_W] != '0) || (req_addr[1:0] != 2'b00);

  // Not reset: the loader may fill the array while the core is held in reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= 2'd0;
      instr_q <= 32'd0;
      fault_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    fault_d = fault_q;
    halt_d  = halt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W-1:0];
          instr_d = 32'd0;
          cnt_d   = 2'd0;
          fault_d = bad_addr;
          state_d = bad_addr ? S_RESP : S_READ;
        end
      end
      S_READ: begin
        unique case (cnt_q)
          2'd0: instr_d[7:0]   = rd_byte;
          2'd1: instr_d[15:8]  = rd_byte;
          2'd2: instr_d[23:16] = rd_byte;
          2'd3: instr_d[31:24] = rd_byte;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_RESP;
          // Word bits [31:21] are the incoming top byte plus bits [23:21] already held.
          if (rd_byte == 8'hFF && instr_q[23:21] == 3'b111) begin
            halt_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_instr = instr_q;
  assign rsp_fault = fault_q;
  assign halt_seen = halt_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed fetches push expectations,
// a negedge monitor checks response timing, data, fault and halt flag.
module tb_imem_responder;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_instr;
  logic              rsp_fault;
  logic              halt_seen;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;

  imem_responder #(.MEM_BYTES(4096), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault),
    .halt_seen (halt_seen),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    logic        halt;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   prev_rise = 0;
  logic model_halt = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: timing/halt checked when rsp_valid rises, payload on handshake.
  always @(negedge clk) begin
    if (rsp_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got a response with none outstanding (cycle %0d)", cyc);
      end else begin
        check("rsp_cycle", cyc, exp_q[0].cyc);
        check("halt_seen", {31'd0, halt_seen}, {31'd0, exp_q[0].halt});
        prev_rise = last_rise;
        last_rise = cyc;
      end
    end
    if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
      check("rsp_instr", rsp_instr, exp_q[0].instr);
      check("rsp_fault", {31'd0, rsp_fault}, {31'd0, exp_q[0].fault});
      void'(exp_q.pop_front());
    end
    prev_valid = rsp_valid;
  end

  task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) load(a + ADDR_W'(k), w[8*k +: 8]);
  endtask

  // Returns one time unit after the accepting edge. Response rises 5 cycles
  // after the acceptance cycle for a normal fetch, 1 cycle after for a fault.
  task automatic fetch(input logic [63:0] pc, input logic [31:0] instr,
                       input logic fault, input bit hold);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = pc;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: got req_ready=0, expected 1 within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    if (!fault && instr[31:21] == 11'h7FF) model_halt = 1'b1;
    e.instr = instr; e.fault = fault; e.halt = model_halt;
    e.cyc = cyc + (fault ? 1 : 5);
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_instr"}, rsp_instr, 32'd0);
    check({tag, "_rsp_fault"}, {31'd0, rsp_fault}, 32'd0);
    check({tag, "_halt_seen"}, {31'd0, halt_seen}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Loads during reset must land in the array.
    load_word(12'h000, 32'h8B100513);
    load_word(12'h004, 32'h00100093);
    load_word(12'h008, 32'h402101B3);
    load_word(12'h010, 32'hFFE00000);
    load_word(12'h014, 32'hFFC00000);
    load_word(12'h020, 32'h44332211);
    load_word(12'hFFC, 32'h12345678);
    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Basic fetch.
    fetch(64'h0, 32'h8B100513, 1'b0, 1'b0);
    drain();

    // Back-to-back with req_valid held; req_ready must be low through READ and RESP.
    fetch(64'h4, 32'h00100093, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_req_ready", {31'd0, req_ready}, 32'd0);
    end
    fetch(64'h8, 32'h402101B3, 1'b0, 1'b0);
    drain();
    check("b2b_spacing", last_rise - prev_rise, 32'd6);

    // Faults: misaligned, just past the end, and high address bit set.
    fetch(64'h2, 32'h0, 1'b1, 1'b0);
    drain();
    fetch(64'h1000, 32'h0, 1'b1, 1'b0);
    drain();
    fetch(64'h8000_0000_0000_0000, 32'h0, 1'b1, 1'b0);
    drain();
    fetch(64'hFFC, 32'h12345678, 1'b0, 1'b0);
    drain();

    // [31:21] = 0x7FE is not HALT; 0x7FF is, and the flag stays set.
    fetch(64'h14, 32'hFFC00000, 1'b0, 1'b0);
    drain();
    fetch(64'h10, 32'hFFE00000, 1'b0, 1'b0);
    drain();
    fetch(64'h4, 32'h00100093, 1'b0, 1'b0);
    fetch(64'h3, 32'h0, 1'b1, 1'b0);
    drain();

    // Backpressure plus write to byte 0x21 on the edge that captures it.
    rsp_ready = 1'b0;
    fetch(64'h20, 32'h44332211, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 12'h021; ld_data = 8'hAA;
    @(posedge clk); #1;
    ld_en = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_instr", rsp_instr, 32'h44332211);
      check("stall_fault", {31'd0, rsp_fault}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();
    fetch(64'h20, 32'h4433AA11, 1'b0, 1'b0);
    drain();

    // Reset in READ aborts the fetch; array contents survive.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h10;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_halt = 1'b0;
    check_reset_outputs("midrst");
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", {31'd0, req_ready}, 32'd1);
    repeat (8) @(negedge clk);
    fetch(64'h0, 32'h8B100513, 1'b0, 1'b0);
    drain();
    fetch(64'h10, 32'hFFE00000, 1'b0, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "global timeout");
  end

endmodule
